// File: rtl/mux4_arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter that feeds a
// mux4_registered datapath.
//   NREQ        number of requesters
//   SEL_W       width of the mux select / requester index
//   arb_state_t arbiter FSM state encoding
//   onehot()    index -> one-hot grant vector
package mux4_arb_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
//   req   in   4  request vector
//   ptr   in   2  index that has highest priority this cycle
//   mask  in   4  requesters to ignore (set bit = excluded, e.g. current owner)
//   valid out  1  at least one eligible requester
//   idx   out  2  first eligible requester scanning ptr, ptr+1, ... (mod 4)
module rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [NREQ-1:0]  mask,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [NREQ-1:0] eligible;
  // rotated[k] is the eligibility of requester (ptr + k) mod 4, so the
  // lowest set bit of rotated is the winner's offset from ptr.
  logic [NREQ-1:0] rotated;

  assign eligible = req & ~mask;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      assign rotated[gi] = eligible[SEL_W'(ptr + SEL_W'(gi))];
    end
  endgenerate

  always_comb begin
    logic [SEL_W-1:0] offset;
    offset = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        offset = SEL_W'(k);
      end
    end
    valid = |rotated;
    idx   = SEL_W'(ptr + offset);
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux4_registered datapath among 4 requesters.
// Level requests become a registered one-hot grant; sel/wr_en drive the mux
// directly. An owner holding its request for HOLD_MAX cycles while someone else
// waits is preempted.
//   HOLD_MAX  max consecutive OWN cycles before forced rotation (>= 1)
//   clk      in   1  system clock
//   rst      in   1  synchronous active-low reset
//   req      in   4  level requests
//   gnt      out  4  one-hot grant, 0 when idle
//   sel      out  2  index of granted requester (holds last value when idle)
//   wr_en    out  1  |gnt
//   busy     out  1  high in OWN
//   preempt  out  1  one-cycle pulse when a grant is taken by the hold limit
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             wr_en,
  output logic             busy,
  output logic             preempt
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state_reg, state_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             preempt_reg, preempt_next;

  logic [SEL_W-1:0] pick_ptr;
  logic [NREQ-1:0]  pick_mask;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;

  // While owning, search for the successor starting just after the owner and
  // excluding it; when idle, search from the stored pointer over everyone.
  assign pick_ptr  = (state_reg == OWN) ? SEL_W'(sel_reg + 1'b1) : ptr_reg;
  assign pick_mask = (state_reg == OWN) ? gnt_reg : '0;
  assign owner_req = |(req & gnt_reg);

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .mask  (pick_mask),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    sel_next     = sel_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    preempt_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = OWN;
          gnt_next   = onehot(pick_idx);
          sel_next   = pick_idx;
          cnt_next   = '0;
        end
      end
      OWN: begin
        if (owner_req) begin
          if (cnt_reg < CNT_LAST) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end else if (pick_valid) begin
            gnt_next     = onehot(pick_idx);
            sel_next     = pick_idx;
            ptr_next     = SEL_W'(sel_reg + 1'b1);
            cnt_next     = '0;
            preempt_next = 1'b1;
          end
          // else: no contention, keep the grant with the counter saturated
        end else begin
          ptr_next = SEL_W'(sel_reg + 1'b1);
          cnt_next = '0;
          if (pick_valid) begin
            // hand over directly so the datapath sees no idle bubble
            gnt_next = onehot(pick_idx);
            sel_next = pick_idx;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      sel_reg     <= '0;
      ptr_reg     <= '0;
      cnt_reg     <= '0;
      preempt_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      sel_reg     <= sel_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      preempt_reg <= preempt_next;
    end
  end

  assign gnt     = gnt_reg;
  assign sel     = sel_reg;
  assign wr_en   = |gnt_reg;
  assign busy    = (state_reg == OWN);
  assign preempt = preempt_reg;

endmodule
